// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths, RV32I field positions and the stage occupancy type
package operand_fetch_pkg;
    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREGS  = 32;
    localparam int REG_X0     = 0;
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: upstream fetch handshake and downstream ALU handshake of the operand stage
interface operand_fetch_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instruction;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instruction;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    modport master (
        output in_valid, in_instruction, in_pc, out_ready,
        input  in_ready, out_valid, out_instruction, out_pc, op_a, op_b
    );
    modport slave (
        input  in_valid, in_instruction, in_pc, out_ready,
        output in_ready, out_valid, out_instruction, out_pc, op_a, op_b
    );
endinterface

// File: rtl/operand_fetch_register_file.sv
// operand_fetch_register_file: architectural registers, two async reads, one sync write, x0 hardwired
module operand_fetch_register_file
    import operand_fetch_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    localparam int RIDX = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [RIDX-1:0] rs1,
    input  logic [RIDX-1:0] rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [RIDX-1:0] wa,
    input  logic [XLEN-1:0] wd
);
    logic [XLEN-1:0] regs [NREGS];
    // write port; x0 writes are dropped so entry 0 keeps its reset value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wa != RIDX'(REG_X0)) begin
            regs[wa] <= wd;
        end
    end
    assign rd1 = (rs1 == RIDX'(REG_X0)) ? '0 : regs[rs1];
    assign rd2 = (rs2 == RIDX'(REG_X0)) ? '0 : regs[rs2];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads rs1/rs2 for the captured instruction and holds it in one register slot for the ALU
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    localparam int RIDX = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    operand_fetch_if.slave  bus,
    input  logic            wb_en,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);
    slot_t           slot, slot_next;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q, op_a_q, op_b_q;
    logic [RIDX-1:0] rs1, rs2, held_rs1, held_rs2;
    logic [XLEN-1:0] rf_a, rf_b, fetch_a, fetch_b;
    logic            wb_live, capture, stall, refresh_a, refresh_b;

    assign rs1       = bus.in_instruction[RS1_LSB +: RIDX];
    assign rs2       = bus.in_instruction[RS2_LSB +: RIDX];
    assign held_rs1  = instr_q[RS1_LSB +: RIDX];
    assign held_rs2  = instr_q[RS2_LSB +: RIDX];
    assign wb_live   = wb_en && wb_rd != RIDX'(REG_X0);
    assign capture   = bus.in_valid && bus.in_ready && !flush;
    assign stall     = slot == SLOT_FULL && !bus.out_ready;
    assign fetch_a   = (wb_live && wb_rd == rs1) ? wb_data : rf_a;
    assign fetch_b   = (wb_live && wb_rd == rs2) ? wb_data : rf_b;
    assign refresh_a = stall && wb_live && wb_rd == held_rs1;
    assign refresh_b = stall && wb_live && wb_rd == held_rs2;

    operand_fetch_register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd1     (rf_a),
        .rd2     (rf_b),
        .we      (wb_en),
        .wa      (wb_rd),
        .wd      (wb_data)
    );

    // occupancy register: EMPTY/FULL is the whole control state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) slot <= SLOT_EMPTY;
        else          slot <= slot_next;
    end

    // flush empties the slot; otherwise a capture fills it and an unconsumed entry stays
    always_comb begin
        slot_next = flush ? SLOT_EMPTY : (capture || stall) ? SLOT_FULL : SLOT_EMPTY;
    end

    // handshake outputs; no skid buffer, so upstream sees the downstream ready directly
    always_comb begin
        bus.out_valid = slot == SLOT_FULL;
        bus.in_ready  = slot == SLOT_EMPTY || bus.out_ready;
    end

    // payload: load on capture, otherwise let a stalled entry pick up writebacks to its sources
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else if (capture) begin
            instr_q <= bus.in_instruction;
            pc_q    <= bus.in_pc;
            op_a_q  <= fetch_a;
            op_b_q  <= fetch_b;
        end else begin
            if (refresh_a) op_a_q <= wb_data;
            if (refresh_b) op_b_q <= wb_data;
        end
    end

    assign bus.out_instruction = instr_q;
    assign bus.out_pc          = pc_q;
    assign bus.op_a            = op_a_q;
    assign bus.op_b            = op_b_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenario tasks for the operand fetch stage
module tb_operand_fetch;
    localparam logic [31:0] ADDI_X6_X5_1  = 32'h0012_8313;
    localparam logic [31:0] ADD_X8_X7_X7  = 32'h0073_8433;
    localparam logic [31:0] ADD_X9_X5_X3  = 32'h0032_84B3;
    localparam logic [31:0] ADD_X10_X0_X0 = 32'h0000_0533;
    localparam logic [31:0] ADD_X13_X12   = 32'h0006_06B3;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        wb_en = 0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 0;
    int          checks = 0;
    int          passed = 0;

    operand_fetch_if #(.XLEN(32)) bus();

    operand_fetch dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .flush   (flush)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.in_valid = 0;
        wb_en = 0;
        flush = 0;
        bus.out_ready = 1;
    endtask

    task automatic test_reset;
        idle();
        bus.in_instruction = '0;
        bus.in_pc = '0;
        #3;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0) $display("FAIL rst_ops got %h/%h want 0/0", bus.op_a, bus.op_b); else passed++;
        checks++; if (bus.out_instruction !== 32'h0 || bus.out_pc !== 32'h0) $display("FAIL rst_payload got %h/%h want 0/0", bus.out_instruction, bus.out_pc); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else passed++;
        @(negedge clk);
        reset_n = 1;
        step();
    endtask

    task automatic test_write_read;
        wb_en = 1; wb_rd = 5; wb_data = 32'h1234_5678;
        step();
        wb_en = 0;
        bus.in_valid = 1; bus.in_instruction = ADDI_X6_X5_1; bus.in_pc = 32'h100;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL wr_pre_valid got %b want 0", bus.out_valid); else passed++;
        step();
        bus.in_valid = 0;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL wr_valid got %b want 1", bus.out_valid); else passed++;
        checks++; if (bus.op_a !== 32'h1234_5678) $display("FAIL wr_op_a got %h want 12345678", bus.op_a); else passed++;
        checks++; if (bus.op_b !== 32'h0) $display("FAIL wr_op_b got %h want 0", bus.op_b); else passed++;
        checks++; if (bus.out_pc !== 32'h100 || bus.out_instruction !== ADDI_X6_X5_1) $display("FAIL wr_payload got %h/%h want 100/%h", bus.out_pc, bus.out_instruction, ADDI_X6_X5_1); else passed++;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL wr_consumed got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_bypass;
        wb_en = 1; wb_rd = 7; wb_data = 32'hDEAD_BEEF;
        bus.in_valid = 1; bus.in_instruction = ADD_X8_X7_X7; bus.in_pc = 32'h104;
        step();
        wb_en = 0;
        bus.in_instruction = ADDI_X6_X5_1; bus.in_pc = 32'h108;
        checks++; if (bus.op_a !== 32'hDEAD_BEEF || bus.op_b !== 32'hDEAD_BEEF) $display("FAIL byp_ops got %h/%h want deadbeef/deadbeef", bus.op_a, bus.op_b); else passed++;
        step();
        bus.in_instruction = ADD_X8_X7_X7; bus.in_pc = 32'h10C;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h108 || bus.op_a !== 32'h1234_5678) $display("FAIL b2b_second got v%b pc %h a %h want v1 pc 108 a 12345678", bus.out_valid, bus.out_pc, bus.op_a); else passed++;
        step();
        bus.in_valid = 0;
        checks++; if (bus.out_pc !== 32'h10C || bus.op_b !== 32'hDEAD_BEEF) $display("FAIL b2b_regfile got pc %h b %h want 10c/deadbeef", bus.out_pc, bus.op_b); else passed++;
        step();
    endtask

    task automatic test_stall;
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_instruction = ADD_X9_X5_X3; bus.in_pc = 32'h200;
        step();
        checks++; if (bus.op_a !== 32'h1234_5678 || bus.op_b !== 32'h0) $display("FAIL stl_ops got %h/%h want 12345678/0", bus.op_a, bus.op_b); else passed++;
        bus.in_instruction = ADD_X10_X0_X0; bus.in_pc = 32'h204;
        wb_en = 1; wb_rd = 3; wb_data = 32'h55;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL stl_in_ready got %b want 0", bus.in_ready); else passed++;
        step();
        wb_en = 0;
        checks++; if (bus.op_b !== 32'h55) $display("FAIL stl_refresh got %h want 55", bus.op_b); else passed++;
        checks++; if (bus.out_pc !== 32'h200 || bus.out_valid !== 1'b1 || bus.op_a !== 32'h1234_5678) $display("FAIL stl_hold got pc %h v%b a %h want 200/1/12345678", bus.out_pc, bus.out_valid, bus.op_a); else passed++;
        bus.in_valid = 0; bus.out_ready = 1;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL stl_drain got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_x0;
        wb_en = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
        bus.in_valid = 1; bus.in_instruction = ADD_X10_X0_X0; bus.in_pc = 32'h280;
        step();
        wb_en = 0;
        checks++; if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0) $display("FAIL x0_bypass got %h/%h want 0/0", bus.op_a, bus.op_b); else passed++;
        bus.in_pc = 32'h284;
        step();
        bus.in_valid = 0;
        checks++; if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0 || bus.out_pc !== 32'h284) $display("FAIL x0_read got %h/%h pc %h want 0/0/284", bus.op_a, bus.op_b, bus.out_pc); else passed++;
        step();
    endtask

    task automatic test_flush;
        bus.in_valid = 1; bus.in_instruction = ADDI_X6_X5_1; bus.in_pc = 32'h300;
        step();
        bus.in_instruction = ADD_X8_X7_X7; bus.in_pc = 32'h304;
        flush = 1; wb_en = 1; wb_rd = 12; wb_data = 32'h77;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL fl_in_ready got %b want 1", bus.in_ready); else passed++;
        step();
        flush = 0; wb_en = 0;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL fl_valid got %b want 0", bus.out_valid); else passed++;
        bus.in_instruction = ADD_X13_X12; bus.in_pc = 32'h308;
        step();
        bus.in_valid = 0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h308) $display("FAIL fl_resume got v%b pc %h want 1/308", bus.out_valid, bus.out_pc); else passed++;
        checks++; if (bus.op_a !== 32'h77) $display("FAIL fl_wb got %h want 77", bus.op_a); else passed++;
        step();
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_instruction = ADDI_X6_X5_1; bus.in_pc = 32'h400;
        step();
        bus.in_valid = 0;
        #2;
        reset_n = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0 || bus.out_pc !== 32'h0) $display("FAIL rm_ops got %h/%h pc %h want 0/0/0", bus.op_a, bus.op_b, bus.out_pc); else passed++;
        @(negedge clk);
        reset_n = 1;
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_instruction = ADDI_X6_X5_1; bus.in_pc = 32'h410;
        step();
        bus.in_valid = 0;
        checks++; if (bus.out_valid !== 1'b1 || bus.op_a !== 32'h0) $display("FAIL rm_x5_cleared got v%b a %h want 1/0", bus.out_valid, bus.op_a); else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_x0();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
